jtcps1_fbwr: RTL
================

# jtcps1_fbwr

Frame-buffer line writer downstream of the CPS1 video mixer. It captures the 12-bit pixel stream during active video into a ping-pong line buffer. After each active line it drains that line, word by word, to an external frame-buffer port using a request/acknowledge handshake. Capture of the next line continues into the other bank while the drain runs.

## Interface
Parameters:
- HW, 384, visible pixels per line; buffer depth per bank is 512.
- DW, 12, pixel width.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous, active-low.
- pxl_cen  in  1  pixel clock enable.
- LHBL  in  1  horizontal blank, active-low (1 = visible).
- LVBL  in  1  vertical blank, active-low (1 = visible).
- vdump  in  9  current video line.
- flip  in  1  screen flip.
- pxl_in  in  DW  pixel from the mixer, sampled on pxl_cen.
- line_data  out  DW  pixel being written.
- line_addr  out  9  horizontal position of line_data.
- line_row  out  9  vdump latched for the line being drained.
- line_wr  out  1  write request.
- line_wr_ok  in  1  write acknowledge.
- busy  out  1  drain in progress.
- overrun  out  1  sticky flag: a line was dropped.

## Operation
- Capture:
  - On pxl_cen with LHBL and LVBL both high, write pxl_in to wr_bank[hcnt], then increment hcnt.
  - hcnt saturates at HW. Pixels beyond HW are discarded.
- End of line: a falling LHBL edge is detected at pxl_cen while LVBL is high and hcnt > 0.
  - If drain is idle: toggle wr_bank, latch len = hcnt, latch line_row = vdump, start the drain.
  - If drain is busy: do not swap banks, set overrun, drop the line.
  - In both cases clear hcnt to 0.
- Drain FSM, states IDLE → RD → WR → (RD | IDLE):
  - IDLE: wait for the start request; set rcnt = 0.
  - RD: issue the buffer read of rd_bank[rcnt]. Synchronous RAM, 1-cycle latency.
  - WR: hold line_wr=1 with line_data and line_addr stable. When line_wr && line_wr_ok, increment rcnt and deassert line_wr on the next cycle. Go to RD if rcnt+1 < len, otherwise go to IDLE.
- line_addr is rcnt.
- busy = (state != IDLE).
- overrun clears on the rising edge of LVBL (start of frame). It is otherwise sticky.
- A start request and a drain completion in the same cycle: the completion is processed first, so the new line is accepted, not dropped.

## Timing
- Reset values:
  - line_wr=0, line_data=0, line_addr=0, line_row=0, busy=0, overrun=0.
  - hcnt=0, wr_bank=0, FSM=IDLE.
- The first line_wr rises 2 clk cycles after the end-of-line detect: one cycle for the start request, one for the RAM read.
- Each word takes at least 2 cycles (RD + WR). With line_wr_ok tied high, HW=384 drains in 768 cycles.
- line_wr_ok is ignored while line_wr=0.
- Reset asserted mid-drain aborts the drain immediately and returns every output to its reset value. No partial write is flagged.

## Configuration
- JTCPS1_FBWR_FLIP_EN:
  - Defined: when flip=1 at line latch time, line_addr = HW-1-rcnt and line_row = 255-vdump (8-bit wrap, 9th bit kept 0).
  - Undefined: the flip input is ignored, line_addr = rcnt, line_row = vdump.

## Test plan
- Single line: push HW=384 pixels with pxl_in=pixel index, then drop LHBL at vdump=20, line_wr_ok held at 1. Expect 384 writes with line_addr 0..383, line_data equal to line_addr, line_row=20, and busy low after the last ack.
- Backpressure: line_wr_ok held low for 5 cycles on every word. Expect line_wr to stay high with data and address unchanged until the ack, and no word skipped or duplicated.
- Overrun: hold line_wr_ok low until a second end-of-line occurs. Expect overrun=1, second line not written, first line still completing intact. Rising LVBL then clears overrun to 0.
- Short/long line: 10 visible pixels produce exactly 10 writes. 500 visible pixels produce exactly 384 writes.
- Reset mid-drain: pull rstn low after 100 acks. Expect line_wr=0 and busy=0 asynchronously. The next line drains normally from line_addr 0.
- Flip (macro defined): flip=1 at vdump=20 gives the first write at line_addr=383 and line_row=235. With the macro undefined, the same stimulus gives line_addr=0 and line_row=20.

Source files
------------

// File: rtl/jtcps1_fbwr.sv
// jtcps1_fbwr: ping-pong line capture of the mixer output, drained word by word to a frame-buffer port
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   pxl_cen, LHBL, LVBL, vdump     pixel enable, blanking (active-low) and current line
//   flip, pxl_in                   screen flip and pixel from the mixer
//   line_data/addr/row, line_wr    frame-buffer write request with line_wr_ok acknowledge
//   busy, overrun                  drain in progress, sticky dropped-line flag (cleared at frame start)
// Optional build macro JTCPS1_FBWR_FLIP_EN: lines latched with flip=1 are written mirrored
//   (line_addr = HW-1-rcnt, line_row = 255-vdump).
module jtcps1_fbwr #(
  parameter int HW = 384,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          LVBL,
  input  logic [8:0]    vdump,
  input  logic          flip,
  input  logic [DW-1:0] pxl_in,
  output logic [DW-1:0] line_data,
  output logic [8:0]    line_addr,
  output logic [8:0]    line_row,
  output logic          line_wr,
  input  logic          line_wr_ok,
  output logic          busy,
  output logic          overrun
);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2;
  localparam logic [8:0] HWL = 9'(HW);
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] rdata_q;
  logic [1:0] st_q, st_d;
  logic [8:0] hcnt_q, len_q, rcnt_q, rcnt_d, row_q, row_d;
  logic wr_bank_q, start_q, lhbl_q, lvbl_q, overrun_q, flip_q;
  logic cap, eol, done, accept;
  assign cap = pxl_cen & LHBL & LVBL & (hcnt_q < HWL);
  assign eol = pxl_cen & lhbl_q & ~LHBL & LVBL & (hcnt_q != 9'd0);
  assign done = (st_q == WR) & line_wr_ok & ({1'b0, rcnt_q} + 10'd1 >= {1'b0, len_q});
  // a drain finishing this very cycle frees the engine for the incoming line
  assign accept = eol & ~start_q & ((st_q == IDLE) | done);
  assign st_d = st_q == IDLE ? (start_q ? RD : IDLE) :
                st_q == RD   ? WR :
                line_wr_ok   ? (done ? IDLE : RD) : WR;
  assign rcnt_d = st_q == IDLE ? 9'd0 : ((st_q == WR) & line_wr_ok) ? rcnt_q + 9'd1 : rcnt_q;
`ifdef JTCPS1_FBWR_FLIP_EN
  assign row_d = flip ? {1'b0, 8'd255 - vdump[7:0]} : vdump;
  assign line_addr = flip_q ? HWL - 9'd1 - rcnt_q : rcnt_q;
`else
  logic unused_flip;
  assign unused_flip = flip;
  assign row_d = vdump;
  assign line_addr = rcnt_q;
`endif
  assign line_data = rdata_q;
  assign line_row = row_q;
  assign line_wr = st_q == WR;
  assign busy = st_q != IDLE;
  assign overrun = overrun_q;
  always_ff @(posedge clk)
    if (cap) mem[{wr_bank_q, hcnt_q}] <= pxl_in;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      st_q      <= IDLE;
      rcnt_q    <= 9'd0;
      hcnt_q    <= 9'd0;
      len_q     <= 9'd0;
      row_q     <= 9'd0;
      rdata_q   <= '0;
      wr_bank_q <= 1'b0;
      start_q   <= 1'b0;
      lhbl_q    <= 1'b0;
      lvbl_q    <= 1'b0;
      overrun_q <= 1'b0;
      flip_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      rcnt_q  <= rcnt_d;
      start_q <= accept | (start_q & (st_q != IDLE));
      lvbl_q  <= LVBL;
      if (pxl_cen) lhbl_q <= LHBL;
      if (cap) hcnt_q <= hcnt_q + 9'd1;
      if (eol) hcnt_q <= 9'd0;
      if (accept) begin
        wr_bank_q <= ~wr_bank_q;
        len_q     <= hcnt_q;
        row_q     <= row_d;
        flip_q    <= flip;
      end
      // the drain always reads the bank that capture is not filling
      if (st_q == RD) rdata_q <= mem[{~wr_bank_q, rcnt_q}];
      overrun_q <= (eol & ~accept) | (overrun_q & ~(LVBL & ~lvbl_q));
    end
endmodule
